// File: rtl/hazard_ctrl.sv
// Decode-stage hazard sequencer: load-use bubbles, data-miss freeze and
// post-redirect squash, with stall-cycle and flush-event counters.
module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int TIMEOUT      = 1024,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_rr,
   input  logic             ex_redirect,
   input  logic             mem_miss,
   input  logic             mem_done,
   output logic             pc_stall,
   output logic             dec_stall,
   output logic             dec_bubble,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_FLUSH} state_t;

   state_t           state_q, state_d;
   logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic             pend_redirect_q, pend_redirect_d;
   logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic             mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_events_q, flush_events_d;
   logic             lu;

   // x0 is hardwired zero, so a load targeting it can never create a hazard.
   assign lu = ex_mem_rr && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));

   always_comb begin
      state_d         = state_q;
      flush_cnt_d     = flush_cnt_q;
      pend_redirect_d = pend_redirect_q;
      wait_cnt_d      = wait_cnt_q;
      mem_timeout_d   = mem_timeout_q;
      flush_events_d  = flush_events_q;
      pc_stall        = 1'b0;
      dec_stall       = 1'b0;
      dec_bubble      = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (mem_miss) begin
               pc_stall   = 1'b1;
               dec_stall  = 1'b1;
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = '0;
               if (ex_redirect) pend_redirect_d = 1'b1;
            end else if (ex_redirect) begin
               dec_bubble     = 1'b1;
               flush_events_d = flush_events_q + CNT_W'(1);
               if (FLUSH_CYCLES > 1) begin
                  state_d     = ST_FLUSH;
                  flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
               end
            end else if (lu) begin
               pc_stall   = 1'b1;
               dec_stall  = 1'b1;
               dec_bubble = 1'b1;
            end
         end

         ST_MEM_WAIT: begin
            pc_stall  = 1'b1;
            dec_stall = 1'b1;
            if (ex_redirect) pend_redirect_d = 1'b1;
            if (mem_done) begin
               if (pend_redirect_q || ex_redirect) begin
                  pend_redirect_d = 1'b0;
                  flush_events_d  = flush_events_q + CNT_W'(1);
                  state_d         = ST_FLUSH;
                  flush_cnt_d     = FC_W'(FLUSH_CYCLES);
               end else begin
                  state_d = ST_RUN;
               end
            end else if (wait_cnt_q == WC_W'(TIMEOUT - 1)) begin
               mem_timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WC_W'(1);
            end
         end

         ST_FLUSH: begin
            dec_bubble  = 1'b1;
            flush_cnt_d = flush_cnt_q - FC_W'(1);
            if (flush_cnt_q <= FC_W'(1)) state_d = ST_RUN;
         end

         default: state_d = ST_RUN;
      endcase

      stall_cycles_d = pc_stall ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_RUN;
         flush_cnt_q     <= '0;
         pend_redirect_q <= 1'b0;
         wait_cnt_q      <= '0;
         mem_timeout_q   <= 1'b0;
         stall_cycles_q  <= '0;
         flush_events_q  <= '0;
      end else begin
         state_q         <= state_d;
         flush_cnt_q     <= flush_cnt_d;
         pend_redirect_q <= pend_redirect_d;
         wait_cnt_q      <= wait_cnt_d;
         mem_timeout_q   <= mem_timeout_d;
         stall_cycles_q  <= stall_cycles_d;
         flush_events_q  <= flush_events_d;
      end
   end

   assign mem_timeout  = mem_timeout_q;
   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: ctl = {pc_stall, dec_stall, dec_bubble}.
module tb_hazard_ctrl;

   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       id_rs1, id_rs2, ex_rd;
   logic             id_uses_rs1, id_uses_rs2, ex_mem_rr, ex_redirect;
   logic             mem_miss, mem_done;
   logic             pc_stall, dec_stall, dec_bubble, mem_timeout;
   logic [CNT_W-1:0] stall_cycles, flush_events;
   logic [2:0]       ctl;

   int total = 0;
   int bad   = 0;

   hazard_ctrl #(.FLUSH_CYCLES(2), .TIMEOUT(8), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_mem_rr(ex_mem_rr), .ex_redirect(ex_redirect),
      .mem_miss(mem_miss), .mem_done(mem_done),
      .pc_stall(pc_stall), .dec_stall(dec_stall), .dec_bubble(dec_bubble),
      .mem_timeout(mem_timeout),
      .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   assign ctl = {pc_stall, dec_stall, dec_bubble};

   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_mem_rr = 1'b0; ex_redirect = 1'b0;
      mem_miss = 1'b0; mem_done = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      total++;
      if ({ctl, mem_timeout} !== 4'b0000 || stall_cycles !== '0 || flush_events !== '0) begin
         bad++;
         $display("FAIL reset: ctl=%b to=%b sc=%0d fe=%0d, want all 0", ctl, mem_timeout, stall_cycles, flush_events);
      end
      $display("reset: ctl=%b to=%b sc=%0d fe=%0d", ctl, mem_timeout, stall_cycles, flush_events);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      ex_mem_rr = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
      #1;
      total++;
      if (ctl !== 3'b111) begin bad++; $display("FAIL lu_rs2: ctl=%b want 111", ctl); end
      $display("lu_rs2: ctl=%b", ctl);
      tick();
      ex_mem_rr = 1'b0;
      #1;
      total++;
      if (ctl !== 3'b000) begin bad++; $display("FAIL lu_clear: ctl=%b want 000", ctl); end
      total++;
      if (stall_cycles !== 32'd1) begin bad++; $display("FAIL lu_count: sc=%0d want 1", stall_cycles); end
      $display("lu_clear: ctl=%b sc=%0d", ctl, stall_cycles);
      clear_inputs();
      ex_mem_rr = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
      #1;
      total++;
      if (ctl !== 3'b111) begin bad++; $display("FAIL lu_rs1: ctl=%b want 111", ctl); end
      $display("lu_rs1: ctl=%b", ctl);
      tick();
      clear_inputs();
   endtask

   task automatic test_no_false_hazard();
      do_reset();
      ex_mem_rr = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
      #1;
      total++;
      if (ctl !== 3'b000) begin bad++; $display("FAIL nf_x0: ctl=%b want 000", ctl); end
      $display("nf_x0: ctl=%b", ctl);
      ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b0;
      #1;
      total++;
      if (ctl !== 3'b000) begin bad++; $display("FAIL nf_unused: ctl=%b want 000", ctl); end
      $display("nf_unused: ctl=%b", ctl);
      ex_mem_rr = 1'b0; id_uses_rs1 = 1'b1;
      #1;
      total++;
      if (ctl !== 3'b000) begin bad++; $display("FAIL nf_notload: ctl=%b want 000", ctl); end
      $display("nf_notload: ctl=%b", ctl);
      tick();
      total++;
      if (stall_cycles !== 32'd0) begin bad++; $display("FAIL nf_count: sc=%0d want 0", stall_cycles); end
      clear_inputs();
   endtask

   task automatic test_redirect();
      do_reset();
      ex_redirect = 1'b1;
      #1;
      total++;
      if (ctl !== 3'b001) begin bad++; $display("FAIL rd_c0: ctl=%b want 001", ctl); end
      $display("rd_c0: ctl=%b", ctl);
      tick();
      // Wrong-path redirect and load-use in the squash cycle are ignored.
      ex_mem_rr = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
      #1;
      total++;
      if (ctl !== 3'b001) begin bad++; $display("FAIL rd_c1: ctl=%b want 001", ctl); end
      total++;
      if (flush_events !== 32'd1) begin bad++; $display("FAIL rd_fe1: fe=%0d want 1", flush_events); end
      $display("rd_c1: ctl=%b fe=%0d", ctl, flush_events);
      tick();
      ex_redirect = 1'b0;
      #1;
      total++;
      if (ctl !== 3'b111) begin bad++; $display("FAIL rd_back_run: ctl=%b want 111", ctl); end
      $display("rd_back_run: ctl=%b", ctl);
      tick();
      clear_inputs();
      #1;
      total++;
      if (ctl !== 3'b000 || flush_events !== 32'd1 || stall_cycles !== 32'd1) begin
         bad++;
         $display("FAIL rd_end: ctl=%b fe=%0d sc=%0d want 000/1/1", ctl, flush_events, stall_cycles);
      end
      $display("rd_end: ctl=%b fe=%0d sc=%0d", ctl, flush_events, stall_cycles);
   endtask

   task automatic test_miss();
      do_reset();
      for (int c = 0; c <= 5; c++) begin
         mem_miss = (c == 0 || c == 2);
         mem_done = (c == 5);
         #1;
         total++;
         if (ctl !== 3'b110) begin bad++; $display("FAIL miss_c%0d: ctl=%b want 110", c, ctl); end
         $display("miss_c%0d: ctl=%b", c, ctl);
         tick();
      end
      clear_inputs();
      #1;
      total++;
      if (ctl !== 3'b000 || stall_cycles !== 32'd6) begin
         bad++;
         $display("FAIL miss_end: ctl=%b sc=%0d want 000/6", ctl, stall_cycles);
      end
      $display("miss_end: ctl=%b sc=%0d", ctl, stall_cycles);
   endtask

   task automatic test_simultaneous();
      logic [2:0] exp_ctl [0:6];
      exp_ctl = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b001, 3'b001, 3'b000};
      do_reset();
      for (int c = 0; c <= 6; c++) begin
         mem_miss    = (c == 0);
         ex_redirect = (c == 0);
         mem_done    = (c == 3);
         #1;
         total++;
         if (ctl !== exp_ctl[c]) begin bad++; $display("FAIL sim_c%0d: ctl=%b want %b", c, ctl, exp_ctl[c]); end
         $display("sim_c%0d: ctl=%b", c, ctl);
         tick();
      end
      clear_inputs();
      total++;
      if (flush_events !== 32'd1 || stall_cycles !== 32'd4) begin
         bad++;
         $display("FAIL sim_count: fe=%0d sc=%0d want 1/4", flush_events, stall_cycles);
      end
      $display("sim_count: fe=%0d sc=%0d", flush_events, stall_cycles);
   endtask

   task automatic test_timeout();
      do_reset();
      mem_miss = 1'b1;
      tick();
      mem_miss = 1'b0;
      // Seven full MEM_WAIT cycles are not yet enough.
      for (int c = 1; c <= 7; c++) tick();
      total++;
      if (mem_timeout !== 1'b0) begin bad++; $display("FAIL to_early: to=%b want 0", mem_timeout); end
      $display("to_early: to=%b", mem_timeout);
      tick();
      total++;
      if (mem_timeout !== 1'b1) begin bad++; $display("FAIL to_set: to=%b want 1", mem_timeout); end
      $display("to_set: to=%b", mem_timeout);
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      #1;
      total++;
      if (mem_timeout !== 1'b1 || ctl !== 3'b000) begin
         bad++;
         $display("FAIL to_sticky: to=%b ctl=%b want 1/000", mem_timeout, ctl);
      end
      $display("to_sticky: to=%b ctl=%b", mem_timeout, ctl);
      mem_miss = 1'b1;
      tick();
      mem_miss = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({ctl, mem_timeout} !== 4'b0000 || stall_cycles !== '0 || flush_events !== '0) begin
         bad++;
         $display("FAIL to_async_rst: ctl=%b to=%b sc=%0d fe=%0d want all 0", ctl, mem_timeout, stall_cycles, flush_events);
      end
      $display("to_async_rst: ctl=%b to=%b sc=%0d", ctl, mem_timeout, stall_cycles);
      tick();
      rst = 1'b0;
      tick();
      #1;
      total++;
      if (ctl !== 3'b000) begin bad++; $display("FAIL to_after_rst: ctl=%b want 000", ctl); end
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_load_use();
      test_no_false_hazard();
      test_redirect();
      test_miss();
      test_simultaneous();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, want finish before 100000");
      $fatal(1);
   end

endmodule
